// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Instruction sequencer for a small multi-cycle CPU. It steps the decoder
//   through FETCH/EXEC1/EXEC2 and waits in MULW while the multiplier runs.
//   It also grants the data RAM port to an external DMA requester, in bursts
//   of at most 16 cycles, and handles halt/run/single-step control.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   run          level, leave HALT and free-run
//   step         pulse, from HALT execute exactly one instruction
//   stop         decoder halt request (EXEC1)
//   sm_extra     decoder request for a third execute cycle (EXEC1)
//   mul_busy     multiplier still computing (EXEC1, MULW)
//   dma_req      external requester wants the data RAM port
//   state        decoder state code: 00 FETCH, 01 EXEC1, 10 EXEC2, 11 idle
//   halted       high while in HALT
//   dma_gnt      high while the requester owns the data RAM port
//   instr_count  instructions that completed EXEC1 (wrapping)
//   stall_count  cycles spent in MULW or DMA (saturating)
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        stop,
  input  logic        sm_extra,
  input  logic        mul_busy,
  input  logic        dma_req,
  output logic [1:0]  state,
  output logic        halted,
  output logic        dma_gnt,
  output logic [15:0] instr_count,
  output logic [15:0] stall_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_MULW,
    S_DMA,
    S_HALT
  } seq_state_t;

  seq_state_t cur_state, nxt_state;
  logic       step_mode, nxt_step_mode;
  logic       dma_allow, nxt_dma_allow;
  logic       dma_from_halt, nxt_dma_from_halt;
  logic [3:0] burst_cnt, nxt_burst_cnt;
  logic       at_boundary;

  // State and control registers; counters update from the current state so
  // every output is a function of registered values only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state     <= S_HALT;
      step_mode     <= 1'b0;
      dma_allow     <= 1'b1;
      dma_from_halt <= 1'b0;
      burst_cnt     <= 4'd0;
      instr_count   <= 16'd0;
      stall_count   <= 16'd0;
    end else begin
      cur_state     <= nxt_state;
      step_mode     <= nxt_step_mode;
      dma_allow     <= nxt_dma_allow;
      dma_from_halt <= nxt_dma_from_halt;
      burst_cnt     <= nxt_burst_cnt;
      if (cur_state == S_EXEC1)
        instr_count <= instr_count + 16'd1;
      if ((cur_state == S_MULW || cur_state == S_DMA) && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  // Next-state logic. States that finish an instruction raise at_boundary,
  // and the shared boundary decision (step return, DMA grant, next fetch)
  // is made once after the case.
  always_comb begin
    nxt_state         = cur_state;
    nxt_step_mode     = step_mode;
    nxt_dma_allow     = dma_allow;
    nxt_dma_from_halt = dma_from_halt;
    nxt_burst_cnt     = burst_cnt;
    at_boundary       = 1'b0;

    case (cur_state)
      S_FETCH: begin
        nxt_state     = S_EXEC1;
        // Re-arming here means the instruction about to execute can itself
        // hand the port back after a forced release.
        nxt_dma_allow = 1'b1;
      end
      S_EXEC1: begin
        if (stop) begin
          nxt_state     = S_HALT;
          nxt_step_mode = 1'b0;
        end else if (sm_extra) begin
          nxt_state = S_EXEC2;
        end else if (mul_busy) begin
          nxt_state = S_MULW;
        end else begin
          at_boundary = 1'b1;
        end
      end
      S_EXEC2: at_boundary = 1'b1;
      S_MULW: begin
        if (!mul_busy)
          at_boundary = 1'b1;
      end
      S_DMA: begin
        nxt_burst_cnt = burst_cnt + 4'd1;
        if (!(dma_req && burst_cnt != 4'hF)) begin
          nxt_state = dma_from_halt ? S_HALT : S_FETCH;
          // Forced release while running blocks re-grant until an
          // instruction has executed; bursts taken from HALT are unlimited.
          if (dma_req && !dma_from_halt)
            nxt_dma_allow = 1'b0;
        end
      end
      S_HALT: begin
        if (dma_req) begin
          nxt_state         = S_DMA;
          nxt_dma_from_halt = 1'b1;
          nxt_burst_cnt     = 4'd0;
        end else if (step) begin
          nxt_state     = S_FETCH;
          nxt_step_mode = 1'b1;
        end else if (run) begin
          nxt_state = S_FETCH;
        end
      end
      default: nxt_state = S_HALT;
    endcase

    if (at_boundary) begin
      if (step_mode) begin
        nxt_state     = S_HALT;
        nxt_step_mode = 1'b0;
      end else if (dma_req && dma_allow) begin
        nxt_state         = S_DMA;
        nxt_dma_from_halt = 1'b0;
        nxt_burst_cnt     = 4'd0;
      end else begin
        nxt_state = S_FETCH;
      end
    end
  end

  // Decoder-facing outputs are decoded from the registered state only.
  always_comb begin
    state   = 2'b11;
    halted  = 1'b0;
    dma_gnt = 1'b0;
    case (cur_state)
      S_FETCH: state = 2'b00;
      S_EXEC1: state = 2'b01;
      S_EXEC2: state = 2'b10;
      S_DMA:   dma_gnt = 1'b1;
      S_HALT:  halted = 1'b1;
      default: state = 2'b11;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer: reset, free-running two-cycle
//   instructions, EXEC2 and multiplier waits, stop with DMA from HALT,
//   burst limiting, reset mid-burst and single-step.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        stop = 1'b0;
  logic        sm_extra = 1'b0;
  logic        mul_busy = 1'b0;
  logic        dma_req = 1'b0;
  logic [1:0]  state;
  logic        halted;
  logic        dma_gnt;
  logic [15:0] instr_count;
  logic [15:0] stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  cpu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .stop        (stop),
    .sm_extra    (sm_extra),
    .mul_busy    (mul_busy),
    .dma_req     (dma_req),
    .state       (state),
    .halted      (halted),
    .dma_gnt     (dma_gnt),
    .instr_count (instr_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one rising edge consume them, then settle
  // 1 time unit past the edge so outputs are sampled away from it.
  task automatic applyStimulus(input logic r, input logic s, input logic sp,
                               input logic ex, input logic mb, input logic dr);
    run      = r;
    step     = s;
    stop     = sp;
    sm_extra = ex;
    mul_busy = mb;
    dma_req  = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_state,
                             input logic exp_halted, input logic exp_gnt,
                             input logic [15:0] exp_instr, input logic [15:0] exp_stall);
    tests_run++;
    assert (state === exp_state) else begin
      tests_failed++;
      $error("[TB] FAIL %s state: observed %b expected %b", tag, state, exp_state);
    end
    tests_run++;
    assert (halted === exp_halted) else begin
      tests_failed++;
      $error("[TB] FAIL %s halted: observed %b expected %b", tag, halted, exp_halted);
    end
    tests_run++;
    assert (dma_gnt === exp_gnt) else begin
      tests_failed++;
      $error("[TB] FAIL %s dma_gnt: observed %b expected %b", tag, dma_gnt, exp_gnt);
    end
    tests_run++;
    assert (instr_count === exp_instr) else begin
      tests_failed++;
      $error("[TB] FAIL %s instr_count: observed %0d expected %0d", tag, instr_count, exp_instr);
    end
    tests_run++;
    assert (stall_count === exp_stall) else begin
      tests_failed++;
      $error("[TB] FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, exp_stall);
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset", 2'b11, 1, 0, 16'd0, 16'd0);
    rst_n = 1'b1;

    // Three two-cycle instructions while running
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_f1", 2'b00, 0, 0, 16'd0, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_e1", 2'b01, 0, 0, 16'd0, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_f2", 2'b00, 0, 0, 16'd1, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_e2", 2'b01, 0, 0, 16'd1, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_f3", 2'b00, 0, 0, 16'd2, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_e3", 2'b01, 0, 0, 16'd2, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("run_done", 2'b00, 0, 0, 16'd3, 16'd0);

    // Three-cycle instruction via EXEC2
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("ex2_e1", 2'b01, 0, 0, 16'd3, 16'd0);
    applyStimulus(1, 0, 0, 1, 0, 0); checkOutput("ex2_e2", 2'b10, 0, 0, 16'd4, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("ex2_f", 2'b00, 0, 0, 16'd4, 16'd0);

    // Multiplier wait: four MULW cycles
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("mul_e1", 2'b01, 0, 0, 16'd4, 16'd0);
    applyStimulus(1, 0, 0, 0, 1, 0); checkOutput("mul_w1", 2'b11, 0, 0, 16'd5, 16'd0);
    applyStimulus(1, 0, 0, 0, 1, 0); checkOutput("mul_w2", 2'b11, 0, 0, 16'd5, 16'd1);
    applyStimulus(1, 0, 0, 0, 1, 0); checkOutput("mul_w3", 2'b11, 0, 0, 16'd5, 16'd2);
    applyStimulus(1, 0, 0, 0, 1, 0); checkOutput("mul_w4", 2'b11, 0, 0, 16'd5, 16'd3);
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("mul_exit", 2'b00, 0, 0, 16'd5, 16'd4);

    // stop beats dma_req in EXEC1, then DMA taken from HALT returns to HALT
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("stop_e1", 2'b01, 0, 0, 16'd5, 16'd4);
    applyStimulus(1, 0, 1, 0, 0, 1); checkOutput("stop_halt", 2'b11, 1, 0, 16'd6, 16'd4);
    applyStimulus(0, 0, 0, 0, 0, 1); checkOutput("hdma_d1", 2'b11, 0, 1, 16'd6, 16'd4);
    applyStimulus(0, 0, 0, 0, 0, 1); checkOutput("hdma_d2", 2'b11, 0, 1, 16'd6, 16'd5);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("hdma_ret", 2'b11, 1, 0, 16'd6, 16'd6);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("halt_hold", 2'b11, 1, 0, 16'd6, 16'd6);

    // Continuous dma_req while running: 16-cycle burst, one instruction, again
    applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("burst_f", 2'b00, 0, 0, 16'd6, 16'd6);
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("burst_e1", 2'b01, 0, 0, 16'd6, 16'd6);
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("burst_g1", 2'b11, 0, 1, 16'd7, 16'd6);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput($sformatf("burst_g%0d", i + 1), 2'b11, 0, 1, 16'd7, 16'(6 + i));
    end
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("burst_rel", 2'b00, 0, 0, 16'd7, 16'd22);
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("burst_ie1", 2'b01, 0, 0, 16'd7, 16'd22);
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("burst_again", 2'b11, 0, 1, 16'd8, 16'd22);

    // Reset during the third DMA cycle
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("rdma_g2", 2'b11, 0, 1, 16'd8, 16'd23);
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("rdma_g3", 2'b11, 0, 1, 16'd8, 16'd24);
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 1); checkOutput("rdma_reset", 2'b11, 1, 0, 16'd0, 16'd0);
    rst_n = 1'b1;

    // Single step (step with run behaves as step), twice
    applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("step1_f", 2'b00, 0, 0, 16'd0, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("step1_e1", 2'b01, 0, 0, 16'd0, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("step1_halt", 2'b11, 1, 0, 16'd1, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("step_idle", 2'b11, 1, 0, 16'd1, 16'd0);
    applyStimulus(0, 1, 0, 0, 0, 0); checkOutput("step2_f", 2'b00, 0, 0, 16'd1, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("step2_e1", 2'b01, 0, 0, 16'd1, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("step2_halt", 2'b11, 1, 0, 16'd2, 16'd0);

    // dma_req in HALT overrides step
    applyStimulus(0, 1, 0, 0, 0, 1); checkOutput("hdma_ovr", 2'b11, 0, 1, 16'd2, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("hdma_ovr_ret", 2'b11, 1, 0, 16'd2, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-003 run  input  1  level; leave HALT and resume free-running execution.
REQ-004 step  input  1  single-cycle pulse; from HALT, execute exactly one instruction then return to HALT.
REQ-005 stop  input  1  decoder halt request; valid only in EXEC1.
REQ-006 sm_extra  input  1  decoder request for EXEC2 (three-cycle instruction); valid in EXEC1.
REQ-007 mul_busy  input  1  multiplier still computing; sampled in EXEC1 and MULW.
REQ-008 dma_req  input  1  external requester wants the data RAM port.
REQ-009 state  output  2  decoder state code: 00 FETCH, 01 EXEC1, 10 EXEC2, 11 idle (MULW/DMA/HALT).
REQ-010 halted  output  1  high while in HALT.
REQ-011 dma_gnt  output  1  high while in DMA; requester owns the data RAM port.
REQ-012 instr_count  output  16  instructions that completed EXEC1.
REQ-013 stall_count  output  16  cycles spent in MULW or DMA.

Function
REQ-014 Internal states: FETCH, EXEC1, EXEC2, MULW, DMA, HALT; state output SHALL be 11 in MULW, DMA and HALT so the decoder asserts no fetch/exec strobes.
REQ-015 All outputs SHALL be registered or decoded from registered state only; no combinational input-to-output path.
REQ-016 FETCH -> EXEC1 unconditionally, next cycle.
REQ-017 EXEC1 priority: stop -> HALT; else sm_extra -> EXEC2; else mul_busy -> MULW; else "boundary".
REQ-018 EXEC2 -> boundary; MULW holds while mul_busy=1, -> boundary when mul_busy=0.
REQ-019 Boundary: if step-mode flag set -> HALT (clear flag); else if dma_req and dma_allow -> DMA; else -> FETCH.
REQ-020 HALT: dma_req -> DMA (return target HALT, overrides run/step); else step -> FETCH with step-mode flag set; else run -> FETCH; else stay.
REQ-021 DMA: stays while dma_req=1 and burst counter < 15; exits on dma_req=0 or the 16th grant cycle, to FETCH (or HALT if entered from HALT).
REQ-022 Burst counter (4 bits) SHALL clear on DMA entry and increment each DMA cycle; forced exit SHALL clear dma_allow.
REQ-023 dma_allow SHALL be set again when EXEC1 is next entered, guaranteeing at least one CPU instruction between forced-release bursts; DMA entered from HALT has no such limit on re-entry.
REQ-024 instr_count SHALL increment by 1 on each EXEC1 cycle, including stop instructions; wraps 0xFFFF -> 0x0000.
REQ-025 stall_count SHALL increment on each MULW or DMA cycle and saturate at 0xFFFF.
REQ-026 stop SHALL override a simultaneous step-mode return or dma_req; run and step are ignored outside HALT.
REQ-027 step asserted together with run SHALL be treated as step.

Reset
REQ-028 While rst_n=0 at a clock edge: state -> HALT (state=11, halted=1), dma_gnt=0, instr_count=0, stall_count=0, burst counter=0, dma_allow=1, step-mode flag=0.
REQ-029 Reset asserted mid-MULW or mid-DMA SHALL abort immediately; dma_gnt drops on the reset edge.

Verification
REQ-030 Reset, run=1, 3 two-cycle instructions -> state 00,01,00,01,00,01; instr_count=3; stall_count=0.
REQ-031 sm_extra=1 in EXEC1 -> state 01 then 10 then 00; mul_busy high for 4 cycles after EXEC1 -> 4 cycles of 11, stall_count=4.
REQ-032 stop=1 in EXEC1 with dma_req=1 -> HALT next cycle; halted=1; then DMA entered from HALT, dma_gnt=1, return to HALT on dma_req=0.
REQ-033 dma_req held high continuously while running -> dma_gnt high exactly 16 cycles, then FETCH, EXEC1, then DMA again.
REQ-034 From HALT, pulse step -> FETCH, EXEC1, HALT; instr_count +1; a second step repeats this.
REQ-035 rst_n=0 during the 3rd DMA cycle -> next cycle dma_gnt=0, state=11, halted=1, counters=0.
